// File: rtl/gs_pkg.sv
// Shared types and constants for the Goldschmidt divide/sqrt sequencer.
// Also holds the per-state output decode, so every state's outputs are defined in one table.
package gs_pkg;

    typedef enum logic [2:0] {
        StIdle, StInit, StMulN, StMulD, StMulD2, StKupd, StRem, StDone
    } gs_state_e;

    localparam logic [1:0] SEL_IN = 2'b00;
    localparam logic [1:0] SEL_N  = 2'b01;
    localparam logic [1:0] SEL_D  = 2'b10;
    localparam logic [1:0] SEL_K  = 2'b11;

    localparam logic [1:0] OP_DIV = 2'b00;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       en_n;
        logic       en_d;
        logic       en_k;
        logic       en_qd;
    } gs_ctrl_t;

    function automatic gs_ctrl_t decode_ctrl(input gs_state_e st);
        gs_ctrl_t c;
        c    = '0;
        c.sa = SEL_IN;
        c.sb = SEL_IN;
        unique case (st)
            StIdle: ;
            StInit: begin
                c.busy = 1'b1;
                c.en_n = 1'b1;
                c.en_d = 1'b1;
                c.en_k = 1'b1;
            end
            StMulN: begin
                c.busy = 1'b1;
                c.sa   = SEL_N;
                c.sb   = SEL_K;
                c.en_n = 1'b1;
            end
            StMulD, StMulD2: begin
                c.busy = 1'b1;
                c.sa   = SEL_D;
                c.sb   = SEL_K;
                c.en_d = 1'b1;
            end
            StKupd: begin
                c.busy = 1'b1;
                c.sa   = SEL_D;
                c.sb   = SEL_K;
                c.en_k = 1'b1;
            end
            StRem: begin
                c.busy  = 1'b1;
                c.sa    = SEL_N;
                c.en_qd = 1'b1;
            end
            StDone: begin
                c.busy = 1'b1;
                c.done = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/iter_counter.sv
// Goldschmidt iteration counter: synchronous clear and increment.
// o_last flags the final iteration, when one more increment would reach ITERS.
module iter_counter #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned ITERS = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_last = (r_count == CNT_W'(ITERS - 1));

endmodule

// File: rtl/goldschmidt_sequencer.sv
// Start/done control FSM for the Goldschmidt divide/sqrt datapath.
// All outputs are registered Moore decodes of the state.
module goldschmidt_sequencer
    import gs_pkg::*;
#(
    parameter int unsigned ITERS = 3,
    parameter int unsigned CNT_W = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [1:0] i_op,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_sA,
    output logic [1:0] o_sB,
    output logic       o_enableN,
    output logic       o_enableD,
    output logic       o_enableK,
    output logic       o_enableQD
);

    if (ITERS < 1 || ITERS >= (1 << CNT_W)) begin : g_bad_iters
        $error("goldschmidt_sequencer: ITERS must be in 1 .. 2**CNT_W-1");
    end

    gs_state_e r_state;
    gs_state_e w_state_nxt;
    gs_ctrl_t  r_ctrl;
    logic      r_is_sqrt;
    logic      w_cnt_clr;
    logic      w_cnt_inc;
    logic      w_last;

    assign w_cnt_clr = (r_state == StInit);
    assign w_cnt_inc = (r_state == StKupd);

    iter_counter #(
        .CNT_W (CNT_W),
        .ITERS (ITERS)
    ) u_iter_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_last  (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  w_state_nxt = i_start ? StInit : StIdle;
            StInit:  w_state_nxt = StMulN;
            StMulN:  w_state_nxt = StMulD;
            StMulD:  w_state_nxt = r_is_sqrt ? StMulD2 : StKupd;
            StMulD2: w_state_nxt = StKupd;
            StKupd:  w_state_nxt = w_last ? StRem : StMulN;
            StRem:   w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_is_sqrt <= 1'b0;
            r_ctrl    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= decode_ctrl(w_state_nxt);
            if (r_state == StIdle && i_start) begin
                r_is_sqrt <= (i_op != OP_DIV);
            end
        end
    end

    assign o_busy     = r_ctrl.busy;
    assign o_done     = r_ctrl.done;
    assign o_sA       = r_ctrl.sa;
    assign o_sB       = r_ctrl.sb;
    assign o_enableN  = r_ctrl.en_n;
    assign o_enableD  = r_ctrl.en_d;
    assign o_enableK  = r_ctrl.en_k;
    assign o_enableQD = r_ctrl.en_qd;

endmodule

// File: tb/tb_goldschmidt_sequencer.sv
// Bench for goldschmidt_sequencer: ITERS=3 and ITERS=1 builds share stimulus and are
// compared every cycle against a queue-of-expected-outputs model of each operation.
module tb_goldschmidt_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;

    always #5 clk = ~clk;

    logic       b3, d3o, n3, dd3, k3, qd3;
    logic [1:0] sa3, sb3;
    logic       b1, d1o, n1, dd1, k1, qd1;
    logic [1:0] sa1, sb1;

    goldschmidt_sequencer #(.ITERS(3), .CNT_W(4)) u_dut3 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op),
        .o_busy(b3), .o_done(d3o), .o_sA(sa3), .o_sB(sb3),
        .o_enableN(n3), .o_enableD(dd3), .o_enableK(k3), .o_enableQD(qd3)
    );

    goldschmidt_sequencer #(.ITERS(1), .CNT_W(4)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op),
        .o_busy(b1), .o_done(d1o), .o_sA(sa1), .o_sB(sb1),
        .o_enableN(n1), .o_enableD(dd1), .o_enableK(k1), .o_enableQD(qd1)
    );

    // {busy, done, sA, sB, enN, enD, enK, enQD}
    logic [9:0] got3, got1;
    assign got3 = {b3, d3o, sa3, sb3, n3, dd3, k3, qd3};
    assign got1 = {b1, d1o, sa1, sb1, n1, dd1, k1, qd1};

    localparam logic [9:0] V_INIT = 10'b1_0_00_00_1110;
    localparam logic [9:0] V_N    = 10'b1_0_01_11_1000;
    localparam logic [9:0] V_D    = 10'b1_0_10_11_0100;
    localparam logic [9:0] V_K    = 10'b1_0_10_11_0010;
    localparam logic [9:0] V_REM  = 10'b1_0_01_00_0001;
    localparam logic [9:0] V_DONE = 10'b1_1_00_00_0000;

    logic [9:0] q3[$];
    logic [9:0] q1[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done3_cyc;
    int done1_cyc;

    task automatic push(input int k, input logic [9:0] v);
        if (k == 0) q3.push_back(v);
        else        q1.push_back(v);
    endtask

    // Whole-operation schedule: INIT, ITERS x (N, D, [D], K), REM, DONE.
    task automatic sched(input int k, input bit sq);
        int iters;
        iters = (k == 0) ? 3 : 1;
        push(k, V_INIT);
        for (int i = 0; i < iters; i++) begin
            push(k, V_N);
            push(k, V_D);
            if (sq) push(k, V_D);
            push(k, V_K);
        end
        push(k, V_REM);
        push(k, V_DONE);
    endtask

    task automatic adv(input int k, input logic s, input logic [1:0] o, input logic r);
        int sz;
        sz = (k == 0) ? q3.size() : q1.size();
        if (r) begin
            if (k == 0) q3.delete();
            else        q1.delete();
        end else if (sz != 0) begin
            if (k == 0) void'(q3.pop_front());
            else        void'(q1.pop_front());
        end else if (s) begin
            sched(k, o != 2'b00);
        end
    endtask

    task automatic check_one(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        assert (got === exp) n_pass += 1;
        else $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        n_checks++;
        assert (got === V_INIT || $countones(got[3:0]) <= 1) n_pass += 1;
        else $error("FAIL %s_onehot cyc=%0d got=%b exp=at_most_one_enable", tag, cyc, got);
    endtask

    task automatic step(input logic s, input logic [1:0] o, input logic r);
        logic [9:0] e3, e1;
        start = s;
        op    = o;
        reset = r;
        @(posedge clk);
        cyc++;
        adv(0, s, o, r);
        adv(1, s, o, r);
        #1;
        e3 = (q3.size() != 0) ? q3[0] : 10'd0;
        e1 = (q1.size() != 0) ? q1[0] : 10'd0;
        check_one("iters3", got3, e3);
        check_one("iters1", got1, e1);
        if (d3o === 1'b1) done3_cyc = cyc;
        if (d1o === 1'b1) done1_cyc = cyc;
    endtask

    task automatic latency(input logic [1:0] o, input int exp3, input int exp1);
        int acc;
        done3_cyc = -1;
        done1_cyc = -1;
        step(1'b1, o, 1'b0);
        acc = cyc;
        for (int i = 0; i < 40 && (done3_cyc < 0 || done1_cyc < 0); i++) begin
            step(1'b0, 2'($urandom), 1'b0);
        end
        n_checks++;
        assert (done3_cyc - acc === exp3) n_pass += 1;
        else $error("FAIL lat3 op=%b got=%0d exp=%0d", o, done3_cyc - acc, exp3);
        n_checks++;
        assert (done1_cyc - acc === exp1) n_pass += 1;
        else $error("FAIL lat1 op=%b got=%0d exp=%0d", o, done1_cyc - acc, exp1);
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        start = 1'b0;
        op    = 2'b00;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 2'($urandom), 1'b0);

        // Latencies: divide 3*ITERS+2, sqrt 4*ITERS+2.
        latency(2'b00, 11, 5);
        latency(2'b01, 14, 6);
        latency(2'b11, 14, 6);
        latency(2'b10, 14, 6);

        // start held high: back-to-back operations, op wandering mid-run.
        for (int i = 0; i < 40; i++) step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 2'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 2'b00, 1'b0);

        // Reset during the second KUPD of a divide, then a clean divide.
        step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b0);
        latency(2'b00, 11, 5);

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) == 0, 2'($urandom), ($urandom % 64) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
